// File: rtl/reservation_station.sv
// Tomasulo-style reservation station: buffers issued instructions, snoops the CDB for
// pending operand tags, and dispatches the oldest ready entry to its functional unit.

module rs_slot #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int SEQ_W  = 3
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              alloc,
    input  logic              clear,
    input  logic [1:0]        new_op,
    input  logic [DATA_W-1:0] new_vj,
    input  logic [DATA_W-1:0] new_vk,
    input  logic [TAG_W-1:0]  new_qj,
    input  logic [TAG_W-1:0]  new_qk,
    input  logic [SEQ_W-1:0]  new_seq,
    input  logic              cdbValid,
    input  logic [TAG_W-1:0]  cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    output logic              busy,
    output logic [1:0]        op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk,
    output logic [TAG_W-1:0]  qj,
    output logic [TAG_W-1:0]  qk,
    output logic [SEQ_W-1:0]  seq,
    output logic              ready
);
    logic hit_new_j, hit_new_k, hit_j, hit_k;

    // Tag 0 means "no producer" and must never match a broadcast.
    assign hit_new_j = cdbValid && (new_qj != '0) && (new_qj == cdbTag);
    assign hit_new_k = cdbValid && (new_qk != '0) && (new_qk == cdbTag);
    assign hit_j     = busy && cdbValid && (qj != '0) && (qj == cdbTag);
    assign hit_k     = busy && cdbValid && (qk != '0) && (qk == cdbTag);
    assign ready     = busy && (qj == '0) && (qk == '0);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            busy <= 1'b0;
            op   <= '0;
            vj   <= '0;
            vk   <= '0;
            qj   <= '0;
            qk   <= '0;
            seq  <= '0;
        end else if (alloc) begin
            busy <= 1'b1;
            op   <= new_op;
            seq  <= new_seq;
            vj   <= hit_new_j ? cdbData : new_vj;
            qj   <= hit_new_j ? '0 : new_qj;
            vk   <= hit_new_k ? cdbData : new_vk;
            qk   <= hit_new_k ? '0 : new_qk;
        end else begin
            if (clear) busy <= 1'b0;
            if (hit_j) begin
                vj <= cdbData;
                qj <= '0;
            end
            if (hit_k) begin
                vk <= cdbData;
                qk <= '0;
            end
        end
    end
endmodule

module reservation_station #(
    parameter int ENTRIES  = 3,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              EN,
    input  logic [1:0]        ALUop,
    input  logic [DATA_W-1:0] vj,
    input  logic [DATA_W-1:0] vk,
    input  logic [TAG_W-1:0]  qj,
    input  logic [TAG_W-1:0]  qk,
    output logic              isFull,
    output logic [TAG_W-1:0]  allocTag,
    input  logic              cdbValid,
    input  logic [TAG_W-1:0]  cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    output logic              fuValid,
    input  logic              fuReady,
    output logic [1:0]        fuOp,
    output logic [DATA_W-1:0] fuVj,
    output logic [DATA_W-1:0] fuVk,
    output logic [TAG_W-1:0]  fuTag
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int SEQ_W = $clog2(ENTRIES) + 1;

    logic [ENTRIES-1:0]             s_busy, s_ready;
    logic [ENTRIES-1:0][1:0]        s_op;
    logic [ENTRIES-1:0][DATA_W-1:0] s_vj, s_vk;
    logic [ENTRIES-1:0][TAG_W-1:0]  s_qj, s_qk;
    logic [ENTRIES-1:0][SEQ_W-1:0]  s_seq, s_age;
    logic [SEQ_W-1:0]               age_cnt;
    logic [IDX_W-1:0]               alloc_idx, sel;
    logic [SEQ_W-1:0]               best_age;
    logic                           do_alloc, have, fire;

    assign isFull   = &s_busy;
    assign do_alloc = EN && !isFull;
    assign fire     = have && fuReady;
    assign allocTag = TAG_W'(TAG_BASE) + (isFull ? '0 : TAG_W'(alloc_idx));

    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!s_busy[i]) alloc_idx = IDX_W'(i);
    end

    // Distance back from the age counter; the largest distance is the oldest entry.
    always_comb begin
        have     = 1'b0;
        sel      = '0;
        best_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (s_ready[i] && (!have || s_age[i] > best_age)) begin
                have     = 1'b1;
                sel      = IDX_W'(i);
                best_age = s_age[i];
            end
        end
    end

    always_comb begin
        fuValid = have;
        fuOp    = '0;
        fuVj    = '0;
        fuVk    = '0;
        fuTag   = '0;
        if (have) begin
            fuOp  = s_op[sel];
            fuVj  = s_vj[sel];
            fuVk  = s_vk[sel];
            fuTag = TAG_W'(TAG_BASE) + TAG_W'(sel);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST)         age_cnt <= '0;
        else if (do_alloc) age_cnt <= age_cnt + 1'b1;
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
        assign s_age[g] = age_cnt - s_seq[g];

        rs_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W), .SEQ_W(SEQ_W)) u_slot (
            .clk      (clk),
            .nRST     (nRST),
            .alloc    (do_alloc && (alloc_idx == IDX_W'(g))),
            .clear    (fire && (sel == IDX_W'(g))),
            .new_op   (ALUop),
            .new_vj   (vj),
            .new_vk   (vk),
            .new_qj   (qj),
            .new_qk   (qk),
            .new_seq  (age_cnt),
            .cdbValid (cdbValid),
            .cdbTag   (cdbTag),
            .cdbData  (cdbData),
            .busy     (s_busy[g]),
            .op       (s_op[g]),
            .vj       (s_vj[g]),
            .vk       (s_vk[g]),
            .qj       (s_qj[g]),
            .qk       (s_qk[g]),
            .seq      (s_seq[g]),
            .ready    (s_ready[g])
        );
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand-written corner sequences,
// and random traffic checked against an allocation-order reference model.

module tb_reservation_station;
    localparam int ENTRIES  = 3;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int TAG_BASE = 1;

    logic              clk, nRST, EN, cdbValid, fuReady;
    logic [1:0]        ALUop, fuOp;
    logic [DATA_W-1:0] vj, vk, cdbData, fuVj, fuVk;
    logic [TAG_W-1:0]  qj, qk, cdbTag, allocTag, fuTag;
    logic              isFull, fuValid;

    int n_chk = 0;
    int n_fail = 0;

    reservation_station #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)) dut (
        .clk(clk), .nRST(nRST), .EN(EN), .ALUop(ALUop), .vj(vj), .vk(vk), .qj(qj), .qk(qk),
        .isFull(isFull), .allocTag(allocTag), .cdbValid(cdbValid), .cdbTag(cdbTag),
        .cdbData(cdbData), .fuValid(fuValid), .fuReady(fuReady), .fuOp(fuOp),
        .fuVj(fuVj), .fuVk(fuVk), .fuTag(fuTag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic [1:0]        op;
        logic [DATA_W-1:0] vj, vk;
        logic [TAG_W-1:0]  qj, qk;
        logic              cv;
        logic [TAG_W-1:0]  ct;
        logic [DATA_W-1:0] cd;
        logic              fr;
        logic              full;
        logic [TAG_W-1:0]  atag;
        logic              fv;
        logic [1:0]        fop;
        logic [DATA_W-1:0] fvj, fvk;
        logic [TAG_W-1:0]  ftag;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input int en, op, a, b, ja, ka, cv, ct, cd, fr,
                                input int full, atag, fv, fop, fvj, fvk, ftag);
        vec_t v;
        v.en = 1'(en);  v.op = 2'(op);  v.vj = DATA_W'(a);  v.vk = DATA_W'(b);
        v.qj = TAG_W'(ja); v.qk = TAG_W'(ka); v.cv = 1'(cv); v.ct = TAG_W'(ct);
        v.cd = DATA_W'(cd); v.fr = 1'(fr); v.full = 1'(full); v.atag = TAG_W'(atag);
        v.fv = 1'(fv); v.fop = 2'(fop); v.fvj = DATA_W'(fvj); v.fvk = DATA_W'(fvk);
        v.ftag = TAG_W'(ftag);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_o(input string nm, input logic full, input logic [TAG_W-1:0] atag,
                            input logic fv, input logic [1:0] fop, input logic [DATA_W-1:0] fvj,
                            input logic [DATA_W-1:0] fvk, input logic [TAG_W-1:0] ftag);
        chk({nm, ".isFull"},   64'(isFull),   64'(full));
        chk({nm, ".allocTag"}, 64'(allocTag), 64'(atag));
        chk({nm, ".fuValid"},  64'(fuValid),  64'(fv));
        chk({nm, ".fuOp"},     64'(fuOp),     64'(fop));
        chk({nm, ".fuVj"},     64'(fuVj),     64'(fvj));
        chk({nm, ".fuVk"},     64'(fuVk),     64'(fvk));
        chk({nm, ".fuTag"},    64'(fuTag),    64'(ftag));
    endtask

    task automatic drive(input int en, op, a, b, ja, ka, cv, ct, cd, fr);
        EN = 1'(en); ALUop = 2'(op); vj = DATA_W'(a); vk = DATA_W'(b);
        qj = TAG_W'(ja); qk = TAG_W'(ka); cdbValid = 1'(cv); cdbTag = TAG_W'(ct);
        cdbData = DATA_W'(cd); fuReady = 1'(fr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    // Reference model: slot contents plus a global allocation number for true age.
    logic              m_busy[ENTRIES];
    logic [1:0]        m_op[ENTRIES];
    logic [DATA_W-1:0] m_vj[ENTRIES], m_vk[ENTRIES];
    logic [TAG_W-1:0]  m_qj[ENTRIES], m_qk[ENTRIES];
    int                m_id[ENTRIES];
    int                next_id;

    function automatic logic [TAG_W-1:0] pick_tag();
        logic [TAG_W-1:0] pool[7] = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd12};
        return pool[$urandom % 7];
    endfunction

    task automatic random_phase(input int cycles);
        for (int i = 0; i < ENTRIES; i++) m_busy[i] = 1'b0;
        next_id = 0;
        for (int c = 0; c < cycles; c++) begin
            int oldest, free_i, sel, cnt;
            logic e, cv, fr, full, fv;
            logic [1:0] op;
            logic [DATA_W-1:0] a, b, cd;
            logic [TAG_W-1:0] ja, ka, ct;

            oldest = -1; free_i = -1; sel = -1; cnt = 0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_busy[i]) begin
                    cnt++;
                    if (oldest < 0 || m_id[i] < m_id[oldest]) oldest = i;
                    if (m_qj[i] == 0 && m_qk[i] == 0 && (sel < 0 || m_id[i] < m_id[sel])) sel = i;
                end else if (free_i < 0) free_i = i;
            end
            full = (cnt == ENTRIES);
            fv   = (sel >= 0);

            e  = ($urandom % 3) != 0;
            // Keep live entries within a few allocations of each other so age stamps never alias.
            if (oldest >= 0 && next_id - m_id[oldest] >= 5) e = 1'b0;
            op = 2'($urandom % 4);
            a  = $urandom; b = $urandom; cd = $urandom;
            ja = ($urandom % 2) ? pick_tag() : '0;
            ka = ($urandom % 3 == 0) ? pick_tag() : '0;
            cv = ($urandom % 5) < 3;
            if (oldest >= 0 && ($urandom % 2) && (m_qj[oldest] != 0 || m_qk[oldest] != 0))
                ct = (m_qj[oldest] != 0) ? m_qj[oldest] : m_qk[oldest];
            else
                ct = ($urandom % 8 == 0) ? '0 : pick_tag();
            fr = ($urandom % 4) != 0;

            drive(e, op, a, b, ja, ka, cv, ct, cd, fr);
            #1;
            if (fv)
                expect_o("rand", full, TAG_W'(TAG_BASE + (full ? 0 : free_i)), 1'b1,
                         m_op[sel], m_vj[sel], m_vk[sel], TAG_W'(TAG_BASE + sel));
            else
                expect_o("rand", full, TAG_W'(TAG_BASE + (full ? 0 : free_i)), 1'b0, 0, 0, 0, 0);

            if (fv && fr) m_busy[sel] = 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_busy[i] && cv && m_qj[i] != 0 && m_qj[i] == ct) begin m_vj[i] = cd; m_qj[i] = '0; end
                if (m_busy[i] && cv && m_qk[i] != 0 && m_qk[i] == ct) begin m_vk[i] = cd; m_qk[i] = '0; end
            end
            if (e && !full) begin
                m_busy[free_i] = 1'b1;
                m_op[free_i]   = op;
                m_vj[free_i]   = (cv && ja != 0 && ja == ct) ? cd : a;
                m_qj[free_i]   = (cv && ja != 0 && ja == ct) ? '0 : ja;
                m_vk[free_i]   = (cv && ka != 0 && ka == ct) ? cd : b;
                m_qk[free_i]   = (cv && ka != 0 && ka == ct) ? '0 : ka;
                m_id[free_i]   = next_id++;
            end
            tick();
        end
    endtask

    initial begin
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        nRST = 1'b1;
        #1;
        expect_o("reset", 0, 1, 0, 0, 0, 0, 0);

        // Basic issue, issue-cycle bypass, fill/full/ignored EN, ordered drain.
        tbl[0]  = mk(1, 0, 5, 7, 0, 0, 0, 0, 0, 1,      0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 2, 1, 0, 5, 7, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 3, 9, 0, 1, 9, 'hAA, 1,   0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 2, 1, 1, 'hAA, 3, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 3, 2, 2, 0, 0, 0, 0, 0, 0,      0, 2, 1, 2, 1, 1, 1);
        tbl[8]  = mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 0,      0, 3, 1, 2, 1, 1, 1);
        tbl[9]  = mk(1, 0, 4, 4, 0, 0, 0, 0, 0, 0,      1, 1, 1, 2, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 1, 2, 1, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 1, 1, 3, 2, 2, 2);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 1, 1, 1, 3, 3, 3);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      0, 1, 0, 0, 0, 0, 0);

        for (int r = 0; r < 14; r++) begin
            EN = tbl[r].en; ALUop = tbl[r].op; vj = tbl[r].vj; vk = tbl[r].vk;
            qj = tbl[r].qj; qk = tbl[r].qk; cdbValid = tbl[r].cv; cdbTag = tbl[r].ct;
            cdbData = tbl[r].cd; fuReady = tbl[r].fr;
            #1;
            expect_o($sformatf("vec%0d", r), tbl[r].full, tbl[r].atag, tbl[r].fv, tbl[r].fop,
                     tbl[r].fvj, tbl[r].fvk, tbl[r].ftag);
            tick();
        end

        // Wake-up by a later CDB broadcast.
        do_reset();
        drive(1, 0, 0, 'h11, 9, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wake.idle.fuValid", 64'(fuValid), 64'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 9, 'h1234, 1);
        #1;
        chk("wake.bcast.fuValid", 64'(fuValid), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        expect_o("wake.disp", 0, 2, 1, 0, 'h1234, 'h11, 1);
        tick();
        expect_o("wake.done", 0, 1, 0, 0, 0, 0, 0);

        // Older waiting entry beats a newer refilled slot once woken.
        do_reset();
        drive(1, 1, 0, 'h5, 9, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2, 'h22, 'h6, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        expect_o("age.first", 0, 3, 1, 2, 'h22, 'h6, 2);
        tick();
        drive(1, 3, 'h33, 'h7, 0, 0, 0, 0, 0, 0);
        #1;
        chk("age.refill.allocTag", 64'(allocTag), 64'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 'h99, 0);
        #1;
        expect_o("age.young", 0, 3, 1, 3, 'h33, 'h7, 2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        expect_o("age.old", 0, 3, 1, 1, 'h99, 'h5, 1);
        tick();
        expect_o("age.next", 0, 1, 1, 3, 'h33, 'h7, 2);
        tick();
        expect_o("age.empty", 0, 1, 0, 0, 0, 0, 0);

        // Reset mid-operation discards pending entries.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, k, k, 9, 0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("rst.pre.isFull", 64'(isFull), 64'd1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        #1;
        expect_o("rst.post", 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 9, 'h55, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        expect_o("rst.bcast", 0, 1, 0, 0, 0, 0, 0);

        do_reset();
        random_phase(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Consumer side of the decode unit's issue interface.
- Accepts one instruction per cycle when its enable bit is set.
- Holds up to ENTRIES instructions, snoops the common data bus (CDB) for outstanding operand tags, and dispatches the oldest ready entry to its functional unit.
- Reports isFull back to the decoder; one instance per functional-unit class (add/sub, multiply, divide).

Parameters:
- ENTRIES, 3, number of station slots (2..8).
- DATA_W, 32, operand width.
- TAG_W, 4, tag width; tag 0 = "value ready, no producer".
- TAG_BASE, 1, tag of slot 0; slot i owns tag TAG_BASE+i (must be nonzero, non-overlapping across instances).

Ports:
- clk  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- EN  in  1  issue enable (this station's ResStationEN bit).
- ALUop  in  2  operation code stored with entry.
- vj  in  DATA_W  operand j value (valid when qj==0).
- vk  in  DATA_W  operand k value (valid when qk==0).
- qj  in  TAG_W  producer tag for j, 0 if ready.
- qk  in  TAG_W  producer tag for k, 0 if ready.
- isFull  out  1  all slots busy.
- allocTag  out  TAG_W  tag the next issue will receive (for register-status update).
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  CDB result tag.
- cdbData  in  DATA_W  CDB result value.
- fuValid  out  1  dispatch request.
- fuReady  in  1  functional unit accepts.
- fuOp  out  2  dispatched ALUop.
- fuVj  out  DATA_W  dispatched operand j.
- fuVk  out  DATA_W  dispatched operand k.
- fuTag  out  TAG_W  tag of dispatched entry (result broadcast tag).

Behaviour:
- Reset (nRST low at clk edge):
  - all busy=0, isFull=0, fuValid=0, fuOp/fuVj/fuVk/fuTag=0, age counter=0.
  - allocTag=TAG_BASE.
  - Reset mid-operation discards every entry; no dispatch in the reset cycle.
- Per-slot state: busy, op, vj, vk, qj, qk, seq (age stamp, width clog2(ENTRIES)+1).
- isFull = AND of registered busy bits; combinational from state only.
  - A slot freed by dispatch this cycle does not lower isFull until the next cycle.
- Allocation:
  - On EN && !isFull, write the lowest-index free slot at the clock edge: busy=1, stamp seq=age counter, age counter increments (wraps).
  - allocTag = TAG_BASE + lowest free index; when full it holds TAG_BASE + 0.
  - EN while isFull is ignored: no state change, no error.
- Issue-cycle CDB bypass: if cdbValid and qj==cdbTag (qj!=0), store vj=cdbData and qj=0. Same rule for k.
- CDB snoop: every cycle, each busy slot with qj==cdbTag (nonzero) and cdbValid loads vj=cdbData and clears qj. Same for k. Both operands may match the same broadcast.
- Ready = busy && qj==0 && qk==0, evaluated on registered state.
  - An entry allocated or woken this cycle is dispatchable one cycle later.
  - Minimum issue-to-dispatch latency is 1 cycle.
- Dispatch select: among ready slots, choose the oldest, compared by seq with wrap-aware difference relative to the age counter. Ties cannot occur.
- Dispatch outputs: fuValid=1 when any slot is ready; fuOp/fuVj/fuVk/fuTag show the selected slot combinationally. When fuValid=0, outputs are 0.
- Handshake: on fuValid && fuReady, the selected slot's busy clears at the edge.
  - fuValid && !fuReady holds the selection stable unless an older entry becomes ready; the selection then changes.
  - The functional unit must sample only on handshake.
- Simultaneous allocate and dispatch in one cycle is legal. The freed slot is not reused that cycle (allocation uses pre-edge busy).
- CDB tag equal to one of this station's own busy slots is legal (dependency between entries of the same unit).

Test Plan:
- Reset, then issue ALUop=0, vj=5, vk=7, qj=qk=0, fuReady=1 -> one cycle later fuValid=1, fuVj=5, fuVk=7, fuTag=TAG_BASE; next cycle fuValid=0.
- Issue with qj=9, qk=0; after 3 cycles drive cdbValid=1, cdbTag=9, cdbData=0x1234 -> fuValid rises the cycle after broadcast with fuVj=0x1234.
- Issue with qj=9 in the same cycle as cdbValid=1, cdbTag=9, cdbData=0xAA -> entry stored ready, dispatch next cycle with fuVj=0xAA.
- fuReady=0, issue 3 ready entries -> isFull=1 and allocTag=TAG_BASE after the third; a 4th EN is ignored. Release fuReady -> dispatch order TAG_BASE, +1, +2; isFull drops the cycle after the first handshake.
- Fill slots 0,1 (slot 0 waits on tag 9), dispatch slot 1, refill slot 1, then broadcast tag 9 -> slot 0 (older seq) dispatches before the refilled slot 1.
- Three entries pending, assert nRST=0 for one cycle -> isFull=0, fuValid=0, allocTag=TAG_BASE; a later CDB broadcast produces no dispatch.
